// File: rtl/iomem_loader_pkg.sv
// Shared definitions for iomem_loader and the command ROM generator:
// op codes, FSM state encoding, command word layout and a word builder.
package iomem_loader_pkg;

   localparam int CMD_W    = 66;
   localparam int OP_LSB   = 64;
   localparam int ADDR_LSB = 32;
   localparam int DATA_LSB = 0;

   localparam logic [3:0] WSTRB_WRITE = 4'b1111;

   typedef enum logic [1:0] {
      OP_END   = 2'b00,
      OP_WRITE = 2'b01,
      OP_READ  = 2'b10,
      OP_DELAY = 2'b11
   } op_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_DECODE,
      ST_BUS,
      ST_DELAY,
      ST_DONE,
      ST_ERROR
   } state_t;

   function automatic logic [CMD_W-1:0] make_cmd(op_t op, logic [31:0] addr, logic [31:0] data);
      return {op, addr, data};
   endfunction

endpackage

// File: rtl/iomem_loader_timer.sv
// Loadable down-counter shared by DELAY waits and the bus timeout.
// last is high while the count sits at 1, i.e. during the final counted cycle.
module iomem_loader_timer #(
   parameter int W = 16
) (
   input  logic         ck,
   input  logic         rst,
   input  logic         load,
   input  logic         en,
   input  logic [W-1:0] value,
   output logic         last
);

   logic [W-1:0] count;

   always_ff @(posedge ck or posedge rst) begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      if (rst)
         count <= '0;
      else if (load)
         count <= value;
      else if (en && count != '0)
         count <= count - W'(1);
   end

   assign last = (count == W'(1));

endmodule

// File: rtl/iomem_loader.sv
// iomem_loader: command-ROM driven iomem master executing WRITE/READ/DELAY/END.
// Define IOMEM_LOADER_TIMEOUT_EN to abort a bus transaction left unanswered for TIMEOUT cycles.
module iomem_loader
   import iomem_loader_pkg::*;
#(
   parameter int CMD_AW  = 6,
   parameter int TIMEOUT = 255
) (
   input  logic              ck,
   input  logic              rst,
   input  logic              start,
   output logic [CMD_AW-1:0] cmd_addr,
   input  logic [CMD_W-1:0]  cmd_data,
   output logic              iomem_valid,
   input  logic              iomem_ready,
   output logic [3:0]        iomem_wstrb,
   output logic [31:0]       iomem_addr,
   output logic [31:0]       iomem_wdata,
   input  logic [31:0]       iomem_rdata,
   output logic [31:0]       rd_data,
   output logic              rd_strobe,
   output logic              busy,
   output logic              done,
   output logic              error
);

   // Counter wide enough for a 16-bit DELAY count or the timeout, whichever is larger.
   localparam int TO_W = $clog2(TIMEOUT + 1);
   localparam int TW   = (TO_W > 16) ? TO_W : 16;

   state_t            state, state_next;
   logic [CMD_AW-1:0] pc;
   op_t               dec_op;
   logic [31:0]       dec_addr, dec_data;
   logic              run_start, run_end, set_done, pc_inc;
   logic              bus_issue, bus_finish, rd_capture;
   logic              tmr_load, tmr_en, tmr_last;
   logic [TW-1:0]     tmr_value;
`ifdef IOMEM_LOADER_TIMEOUT_EN
   logic              set_error;
`endif

   assign dec_op   = op_t'(cmd_data[OP_LSB +: 2]);
   assign dec_addr = cmd_data[ADDR_LSB +: 32];
   assign dec_data = cmd_data[DATA_LSB +: 32];
   assign cmd_addr = pc;

   iomem_loader_timer #(.W(TW)) u_timer (
      .ck    (ck),
      .rst   (rst),
      .load  (tmr_load),
      .en    (tmr_en),
      .value (tmr_value),
      .last  (tmr_last)
   );

   always_ff @(posedge ck or posedge rst) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_next;
   end

   always_comb begin
      // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
      state_next = state;
      run_start  = 1'b0;
      run_end    = 1'b0;
      set_done   = 1'b0;
      pc_inc     = 1'b0;
      bus_issue  = 1'b0;
      bus_finish = 1'b0;
      rd_capture = 1'b0;
      tmr_load   = 1'b0;
      tmr_en     = 1'b0;
      tmr_value  = '0;
`ifdef IOMEM_LOADER_TIMEOUT_EN
      set_error  = 1'b0;
`endif
      case (state)
         ST_IDLE, ST_DONE, ST_ERROR: begin
            if (start) begin
               run_start  = 1'b1;
               state_next = ST_FETCH;
            end
         end
         ST_FETCH: state_next = ST_DECODE;
         ST_DECODE: begin
            case (dec_op)
               OP_END: begin
                  set_done   = 1'b1;
                  run_end    = 1'b1;
                  state_next = ST_DONE;
               end
               OP_WRITE, OP_READ: begin
                  bus_issue  = 1'b1;
                  state_next = ST_BUS;
`ifdef IOMEM_LOADER_TIMEOUT_EN
                  tmr_load   = 1'b1;
                  tmr_value  = TW'(TIMEOUT);
`endif
               end
               OP_DELAY: begin
                  pc_inc = 1'b1;
                  if (dec_data[15:0] == 16'd0) begin
                     state_next = ST_FETCH;
                  end else begin
                     tmr_load   = 1'b1;
                     tmr_value  = TW'(dec_data[15:0]);
                     state_next = ST_DELAY;
                  end
               end
               default: state_next = ST_IDLE;
            endcase
         end
         ST_BUS: begin
            // A read is the only transaction issued with all strobes low.
            if (iomem_ready) begin
               bus_finish = 1'b1;
               pc_inc     = 1'b1;
               rd_capture = (iomem_wstrb == '0);
               state_next = ST_FETCH;
            end
`ifdef IOMEM_LOADER_TIMEOUT_EN
            else if (tmr_last) begin
               bus_finish = 1'b1;
               set_error  = 1'b1;
               run_end    = 1'b1;
               state_next = ST_ERROR;
            end
            else begin
               tmr_en = 1'b1;
            end
`endif
         end
         ST_DELAY: begin
            tmr_en = 1'b1;
            if (tmr_last) state_next = ST_FETCH;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge ck or posedge rst) begin
      if (rst) begin
         pc          <= '0;
         iomem_valid <= 1'b0;
         iomem_wstrb <= '0;
         iomem_addr  <= '0;
         iomem_wdata <= '0;
         rd_data     <= '0;
         rd_strobe   <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
      end else begin
         rd_strobe <= rd_capture;
         if (run_start) begin
            pc   <= '0;
            busy <= 1'b1;
            done <= 1'b0;
         end
         if (pc_inc) pc <= pc + 1'b1;
         if (bus_issue) begin
            iomem_valid <= 1'b1;
            iomem_addr  <= dec_addr;
            iomem_wdata <= dec_data;
            iomem_wstrb <= (dec_op == OP_WRITE) ? WSTRB_WRITE : '0;
         end
         if (bus_finish) begin
            iomem_valid <= 1'b0;
            iomem_wstrb <= '0;
         end
         if (rd_capture) rd_data <= iomem_rdata;
         if (run_end)    busy <= 1'b0;
         if (set_done)   done <= 1'b1;
      end
   end

`ifdef IOMEM_LOADER_TIMEOUT_EN
   always_ff @(posedge ck or posedge rst) begin
      if (rst)            error <= 1'b0;
      else if (run_start) error <= 1'b0;
      else if (set_error) error <= 1'b1;
   end
`else
   assign error = 1'b0;
`endif

endmodule

// File: tb/tb_iomem_loader.sv
// Self-checking bench for iomem_loader: ROM model, randomized responder and a
// program-level reference model of the expected bus transactions and their spacing.
module tb_iomem_loader;
   import iomem_loader_pkg::*;

`ifdef IOMEM_LOADER_TIMEOUT_EN
   localparam int TO = 8;
`else
   localparam int TO = 255;
`endif

   typedef struct {
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
      int          gap;
   } txn_t;

   logic        ck, rst, start;
   logic [5:0]  cmd_addr;
   logic [65:0] cmd_data;
   logic        iomem_valid, iomem_ready;
   logic [3:0]  iomem_wstrb;
   logic [31:0] iomem_addr, iomem_wdata, iomem_rdata, rd_data;
   logic        rd_strobe, busy, done, error;

   logic [65:0] rom [0:63];
   txn_t        obs[$];
   int          errors = 0;
   int          checks = 0;
   int          low_cnt = 0;
   int          vh_cnt = 0;
   bit          start_mark = 0;
   bit          delay_mode = 0;
   int          fixed_delay = 0;
   bit          spurious_en = 0;
   bit          force_rd = 0;
   bit          wrap_mode = 0;

   iomem_loader #(.CMD_AW(6), .TIMEOUT(TO)) dut (
      .ck          (ck),
      .rst         (rst),
      .start       (start),
      .cmd_addr    (cmd_addr),
      .cmd_data    (cmd_data),
      .iomem_valid (iomem_valid),
      .iomem_ready (iomem_ready),
      .iomem_wstrb (iomem_wstrb),
      .iomem_addr  (iomem_addr),
      .iomem_wdata (iomem_wdata),
      .iomem_rdata (iomem_rdata),
      .rd_data     (rd_data),
      .rd_strobe   (rd_strobe),
      .busy        (busy),
      .done        (done),
      .error       (error)
   );

   initial begin
      ck = 1'b0;
      forever #5 ck = ~ck;
   end

   // Synchronous ROM, one cycle read latency.
   always @(posedge ck) cmd_data <= rom[cmd_addr];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Responder and bus monitor: samples on the falling edge, then drives ready/rdata.
   initial begin : responder
      int          wait_cnt;
      logic [31:0] h_addr, h_wdata, hs_rdata;
      logic [3:0]  h_wstrb;
      bit          held_v, hs_prev, hs_read;
      int          cur_gap;
      txn_t        t;
      wait_cnt = 0; held_v = 0; hs_prev = 0; hs_read = 0; cur_gap = 0;
      h_addr = '0; h_wdata = '0; h_wstrb = '0; hs_rdata = '0;
      iomem_ready = 1'b0;
      iomem_rdata = '0;
      forever begin
         @(negedge ck);
         if (rst) begin
            iomem_ready = 1'b0;
            held_v = 0;
            hs_prev = 0;
            continue;
         end
         if (start_mark) begin
            low_cnt = 0;
            vh_cnt = 0;
            start_mark = 0;
         end
         if (hs_prev) begin
            check("valid_drop", 32'(iomem_valid), 32'd0);
            if (hs_read) begin
               check("rd_strobe", 32'(rd_strobe), 32'd1);
               check("rd_data", rd_data, hs_rdata);
            end else begin
               check("rd_strobe_wr", 32'(rd_strobe), 32'd0);
            end
         end else begin
            check("rd_strobe_idle", 32'(rd_strobe), 32'd0);
         end
         hs_prev = 0;
         if (!iomem_valid) begin
            check("wstrb_idle", 32'(iomem_wstrb), 32'd0);
            held_v = 0;
            low_cnt++;
            iomem_ready = spurious_en && ($urandom_range(0, 3) == 0);
            iomem_rdata = $urandom;
         end else begin
            vh_cnt++;
            if (held_v) begin
               check("hold_addr", iomem_addr, h_addr);
               check("hold_wdata", iomem_wdata, h_wdata);
               check("hold_wstrb", 32'(iomem_wstrb), 32'(h_wstrb));
            end else begin
               h_addr   = iomem_addr;
               h_wdata  = iomem_wdata;
               h_wstrb  = iomem_wstrb;
               cur_gap  = low_cnt;
               wait_cnt = delay_mode ? int'($urandom_range(0, 4)) : fixed_delay;
            end
            if (wait_cnt == 0) begin
               hs_rdata    = force_rd ? 32'h8504_2000 : $urandom;
               iomem_rdata = hs_rdata;
               iomem_ready = 1'b1;
               t.addr  = h_addr;
               t.wdata = h_wdata;
               t.wstrb = h_wstrb;
               t.gap   = cur_gap;
               obs.push_back(t);
               if (wrap_mode && obs.size() == 2) rom[0] = make_cmd(OP_END, 32'h0, 32'h0);
               hs_prev = 1;
               hs_read = (h_wstrb == 4'b0000);
               held_v  = 0;
               low_cnt = 0;
            end else begin
               iomem_ready = 1'b0;
               iomem_rdata = $urandom;
               wait_cnt--;
               held_v = 1;
            end
         end
      end
   end

   // Reference model: walks the program and lists the transactions it must produce.
   // gap is the number of valid-low cycles before each request: fetch+decode per
   // command, plus N cycles for every DELAY N.
   task automatic model(output txn_t q[$]);
      int          pc, gap;
      logic [65:0] c;
      txn_t        t;
      q = {};
      pc = 0;
      gap = 2;
      for (int s = 0; s < 256; s++) begin
         c = rom[pc];
         if (c[65:64] == 2'b00) break;
         if (c[65:64] == 2'b11) begin
            gap = gap + 2 + int'(c[15:0]);
         end else begin
            t.addr  = c[63:32];
            t.wdata = c[31:0];
            t.wstrb = (c[65:64] == 2'b01) ? 4'b1111 : 4'b0000;
            t.gap   = gap;
            q.push_back(t);
            gap = 2;
         end
         pc = (pc + 1) % 64;
      end
   endtask

   task automatic clear_rom();
      for (int i = 0; i < 64; i++) rom[i] = make_cmd(OP_END, 32'h0, 32'h0);
   endtask

   task automatic pulse_start();
      @(negedge ck);
      #1 start = 1'b1;
      start_mark = 1;
      @(negedge ck);
      #1 start = 1'b0;
   endtask

   task automatic wait_end(input string tag);
      bit fin;
      fin = 0;
      for (int i = 0; i < 4000 && !fin; i++) begin
         @(negedge ck);
         fin = done || error;
      end
      check({tag, "_finished"}, 32'(fin), 32'd1);
   endtask

   task automatic run_prog(input string tag, input txn_t exp[$], input bit extra_start);
      obs.delete();
      pulse_start();
      check({tag, "_busy_run"}, 32'(busy), 32'd1);
      check({tag, "_done_clr"}, 32'(done), 32'd0);
      if (extra_start) begin
         repeat (2) @(negedge ck);
         #1 start = 1'b1;
         @(negedge ck);
         #1 start = 1'b0;
      end
      wait_end(tag);
      check({tag, "_done"}, 32'(done), 32'd1);
      check({tag, "_busy_end"}, 32'(busy), 32'd0);
      check({tag, "_error"}, 32'(error), 32'd0);
      check({tag, "_count"}, 32'(obs.size()), 32'(exp.size()));
      foreach (exp[i]) begin
         if (i < obs.size()) begin
            check({tag, "_addr"}, obs[i].addr, exp[i].addr);
            check({tag, "_wdata"}, obs[i].wdata, exp[i].wdata);
            check({tag, "_wstrb"}, 32'(obs[i].wstrb), 32'(exp[i].wstrb));
            check({tag, "_gap"}, 32'(obs[i].gap), 32'(exp[i].gap));
         end
      end
   endtask

   task automatic rand_prog();
      int n, k;
      clear_rom();
      n = $urandom_range(1, 10);
      for (int i = 0; i < n; i++) begin
         k = $urandom_range(0, 3);
         case (k)
            0, 1:    rom[i] = make_cmd(OP_WRITE, $urandom, $urandom);
            2:       rom[i] = make_cmd(OP_READ, $urandom, $urandom);
            default: rom[i] = make_cmd(OP_DELAY, 32'h0, 32'($urandom_range(0, 12)));
         endcase
      end
   endtask

   initial begin : main
      txn_t exp[$];
      txn_t t;
      bit   seen;
      rst = 1'b1;
      start = 1'b0;
      clear_rom();
      repeat (3) @(negedge ck);

      check("rst_valid", 32'(iomem_valid), 32'd0);
      check("rst_wstrb", 32'(iomem_wstrb), 32'd0);
      check("rst_addr", iomem_addr, 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_error", 32'(error), 32'd0);
      check("rst_cmd_addr", 32'(cmd_addr), 32'd0);
      rst = 1'b0;
      repeat (5) @(negedge ck);
      check("idle_busy", 32'(busy), 32'd0);
      check("idle_valid", 32'(iomem_valid), 32'd0);
      check("idle_cmd_addr", 32'(cmd_addr), 32'd0);

      // Single write, then END.
      rom[0] = make_cmd(OP_WRITE, 32'h6200_0000, 32'h0000_0003);
      fixed_delay = 2;
      model(exp);
      run_prog("write_end", exp, 0);

      // Single read with a fixed responder value.
      clear_rom();
      rom[0] = make_cmd(OP_READ, 32'h6000_0000, 32'h0);
      force_rd = 1;
      model(exp);
      run_prog("read", exp, 0);
      check("read_rd_data", rd_data, 32'h8504_2000);
      force_rd = 0;

      // Ready held off 5 cycles; a start pulse mid-transaction must be ignored.
      clear_rom();
      rom[0] = make_cmd(OP_WRITE, 32'h6200_0010, 32'hDEAD_BEEF);
      fixed_delay = 5;
      model(exp);
      run_prog("slow_ready", exp, 1);
      check("slow_ready_vh", 32'(vh_cnt), 32'd6);

      // DELAY 10 between two writes.
      clear_rom();
      rom[0] = make_cmd(OP_WRITE, 32'h6200_0020, 32'h1);
      rom[1] = make_cmd(OP_DELAY, 32'h0, 32'd10);
      rom[2] = make_cmd(OP_WRITE, 32'h6200_0024, 32'h2);
      fixed_delay = 0;
      model(exp);
      run_prog("delay10", exp, 0);
      check("delay10_gap", (obs.size() > 1) ? 32'(obs[1].gap) : 32'hFFFF_FFFF, 32'd14);

      // Randomized programs, random ready latency, stray ready while idle.
      delay_mode = 1;
      spurious_en = 1;
      for (int r = 0; r < 25; r++) begin
         rand_prog();
         model(exp);
         run_prog("rand", exp, 0);
      end
      delay_mode = 0;
      spurious_en = 0;

      // Program counter wrap: entry 63 is followed by entry 0, which becomes END.
      clear_rom();
      rom[0] = make_cmd(OP_WRITE, 32'h6200_0100, 32'hA);
      for (int i = 1; i < 63; i++) rom[i] = make_cmd(OP_DELAY, 32'h0, 32'h0);
      rom[63] = make_cmd(OP_WRITE, 32'h6200_0104, 32'hB);
      exp = {};
      t.addr = 32'h6200_0100; t.wdata = 32'hA; t.wstrb = 4'b1111; t.gap = 2;
      exp.push_back(t);
      t.addr = 32'h6200_0104; t.wdata = 32'hB; t.wstrb = 4'b1111; t.gap = 2 + 62 * 2;
      exp.push_back(t);
      wrap_mode = 1;
      run_prog("wrap", exp, 0);
      wrap_mode = 0;

`ifdef IOMEM_LOADER_TIMEOUT_EN
      // Ready never arrives: abort after TIMEOUT cycles, next start clears error.
      clear_rom();
      rom[0] = make_cmd(OP_WRITE, 32'h6200_0200, 32'h5);
      fixed_delay = 1000;
      obs.delete();
      pulse_start();
      wait_end("timeout");
      check("timeout_error", 32'(error), 32'd1);
      check("timeout_busy", 32'(busy), 32'd0);
      check("timeout_done", 32'(done), 32'd0);
      check("timeout_valid", 32'(iomem_valid), 32'd0);
      check("timeout_vh", 32'(vh_cnt), 32'(TO));
      check("timeout_txn", 32'(obs.size()), 32'd0);
      clear_rom();
      pulse_start();
      check("restart_error_clr", 32'(error), 32'd0);
      wait_end("restart");
      check("restart_done", 32'(done), 32'd1);
`endif

      // Reset while a transaction is pending.
      clear_rom();
      rom[0] = make_cmd(OP_DELAY, 32'h0, 32'h0);
      rom[1] = make_cmd(OP_WRITE, 32'h6200_0300, 32'hA5);
      fixed_delay = 1000;
      pulse_start();
      seen = 0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge ck);
         seen = iomem_valid;
      end
      check("rst_bus_reached", 32'(seen), 32'd1);
      #2 rst = 1'b1;
      #1;
      check("arst_valid", 32'(iomem_valid), 32'd0);
      check("arst_wstrb", 32'(iomem_wstrb), 32'd0);
      check("arst_addr", iomem_addr, 32'd0);
      check("arst_wdata", iomem_wdata, 32'd0);
      check("arst_rd_data", rd_data, 32'd0);
      check("arst_rd_strobe", 32'(rd_strobe), 32'd0);
      check("arst_busy", 32'(busy), 32'd0);
      check("arst_done", 32'(done), 32'd0);
      check("arst_error", 32'(error), 32'd0);
      check("arst_cmd_addr", 32'(cmd_addr), 32'd0);
      repeat (2) @(negedge ck);
      rst = 1'b0;
      repeat (6) @(negedge ck);
      check("post_rst_busy", 32'(busy), 32'd0);
      check("post_rst_valid", 32'(iomem_valid), 32'd0);
      check("post_rst_cmd_addr", 32'(cmd_addr), 32'd0);

      clear_rom();
      rom[0] = make_cmd(OP_WRITE, 32'h6200_0400, 32'h77);
      fixed_delay = 1;
      model(exp);
      run_prog("after_rst", exp, 0);

      repeat (3) @(negedge ck);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
